// File: rtl/door_sensor_conditioner.sv
// Presence-sensor front end: synchronises the raw sensor line, debounces both
// edges, stretches presence by a hold-open time and flags a stuck-active
// sensor. All outputs are registered and change on the state-transition edge.
module door_sensor_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int STUCK_CYCLES    = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_sensor,
  output logic sensor_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic fault
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int SW = $clog2(STUCK_CYCLES + 1) + 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_ONE  = HW'(1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SCNT_ONE  = SW'(1);
  localparam logic [SW-1:0] SCNT_MAX  = '1;
  // With STUCK_CYCLES=0 the compare value is unused; keep it non-negative.
  localparam logic [SW-1:0] SCNT_LAST = SW'((STUCK_CYCLES == 0) ? 0 : STUCK_CYCLES - 1);
  localparam bit            STUCK_EN  = (STUCK_CYCLES != 0);
  localparam bit            DEB_ONE   = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [2:0] {IDLE, QUAL_ON, ACTIVE, QUAL_OFF, HOLD, FAULT} state_t;

  logic [SYNC_STAGES-1:0] sync_reg, sync_next;
  logic                   s;
  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [HW-1:0]          hcnt_reg, hcnt_next;
  logic [SW-1:0]          scnt_reg, scnt_next, scnt_inc;
  logic                   sensor_out_reg, sensor_out_next;
  logic                   rise_pulse_reg, rise_pulse_next;
  logic                   fall_pulse_reg, fall_pulse_next;
  logic                   fault_reg, fault_next;

  // Synchroniser chain wiring: stage 0 takes the raw line, each later stage
  // takes its predecessor.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign sync_next[gi] = raw_sensor;
    end else begin : g_rest
      assign sync_next[gi] = sync_reg[gi-1];
    end
  end

  assign s        = sync_reg[SYNC_STAGES-1];
  // Stuck counter saturates so a long presence can never wrap back to zero.
  assign scnt_inc = (scnt_reg == SCNT_MAX) ? scnt_reg : scnt_reg + SCNT_ONE;

  // Synchroniser flops, FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg       <= '0;
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      hcnt_reg       <= '0;
      scnt_reg       <= '0;
      sensor_out_reg <= 1'b0;
      rise_pulse_reg <= 1'b0;
      fall_pulse_reg <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      sync_reg       <= sync_next;
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      hcnt_reg       <= hcnt_next;
      scnt_reg       <= scnt_next;
      sensor_out_reg <= sensor_out_next;
      rise_pulse_reg <= rise_pulse_next;
      fall_pulse_reg <= fall_pulse_next;
      fault_reg      <= fault_next;
    end
  end

  // Next-state, counter updates and next output values.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    hcnt_next       = hcnt_reg;
    scnt_next       = scnt_reg;
    rise_pulse_next = 1'b0;
    fall_pulse_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (s) begin
          if (DEB_ONE) begin
            state_next      = ACTIVE;
            scnt_next       = '0;
            rise_pulse_next = 1'b1;
          end else begin
            state_next = QUAL_ON;
            cnt_next   = CNT_ONE;
          end
        end
      end
      QUAL_ON: begin
        if (!s) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next      = ACTIVE;
          scnt_next       = '0;
          rise_pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ACTIVE: begin
        scnt_next = scnt_inc;
        // The stuck check wins over a release seen on the same clock.
        if (STUCK_EN && scnt_reg == SCNT_LAST) begin
          state_next      = FAULT;
          cnt_next        = '0;
          fall_pulse_next = 1'b1;
        end else if (!s) begin
          if (DEB_ONE) begin
            state_next = HOLD;
            hcnt_next  = '0;
          end else begin
            state_next = QUAL_OFF;
            cnt_next   = CNT_ONE;
          end
        end
      end
      QUAL_OFF: begin
        scnt_next = scnt_inc;
        if (STUCK_EN && scnt_reg == SCNT_LAST) begin
          state_next      = FAULT;
          cnt_next        = '0;
          fall_pulse_next = 1'b1;
        end else if (s) begin
          state_next = ACTIVE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HOLD;
          hcnt_next  = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      HOLD: begin
        // Retrigger during hold-open: straight back to ACTIVE, no pulse.
        if (s) begin
          state_next = ACTIVE;
          scnt_next  = '0;
        end else if (hcnt_reg == HCNT_LAST) begin
          state_next      = IDLE;
          fall_pulse_next = 1'b1;
        end else begin
          hcnt_next = hcnt_reg + HCNT_ONE;
        end
      end
      FAULT: begin
        // Needs an unbroken run of released samples to recover.
        if (s) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    sensor_out_next = (state_next == ACTIVE) || (state_next == QUAL_OFF) ||
                      (state_next == HOLD);
    fault_next      = (state_next == FAULT);
  end

  assign sensor_out = sensor_out_reg;
  assign rise_pulse = rise_pulse_reg;
  assign fall_pulse = fall_pulse_reg;
  assign fault      = fault_reg;

endmodule

// File: tb/tb_door_sensor_conditioner.sv
// Bench for door_sensor_conditioner: the stimulus pushes expected output
// events (edge index plus output levels) into a queue; a monitor pops and
// compares whenever the DUT shows a pulse or an output level change.
module tb_door_sensor_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_sensor = 1'b1;

  logic sensor_out, rise_pulse, fall_pulse, fault;
  logic z_sensor_out, z_rise_pulse, z_fall_pulse, z_fault;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  logic z_fault_seen = 1'b0;

  typedef struct {
    int   cyc;
    logic rise;
    logic fall;
    logic flt;
    logic so;
  } ev_t;

  ev_t exp_q[$];

  door_sensor_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .STUCK_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .raw_sensor(raw_sensor),
    .sensor_out(sensor_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .fault(fault)
  );

  // Same stimulus, stuck detection disabled.
  door_sensor_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .STUCK_CYCLES(0)
  ) dut_nostuck (
    .clk(clk), .rst(rst), .raw_sensor(raw_sensor),
    .sensor_out(z_sensor_out), .rise_pulse(z_rise_pulse),
    .fall_pulse(z_fall_pulse), .fault(z_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
      $display("check %s ok: got %0h", name, act);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int c, input logic r, input logic f,
                           input logic flt, input logic so);
    ev_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.flt = flt; e.so = so;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: samples 3 time units after each rising edge.
  initial begin : monitor
    logic so_prev;
    logic flt_prev;
    ev_t  e;
    so_prev  = 1'b0;
    flt_prev = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (z_fault) z_fault_seen = 1'b1;
      if (rst) begin
        so_prev  = 1'b0;
        flt_prev = 1'b0;
      end else if (rise_pulse || fall_pulse || fault != flt_prev || sensor_out != so_prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: cyc=%0d rise=%b fall=%b fault=%b so=%b, no event expected",
                   cyc, rise_pulse, fall_pulse, fault, sensor_out);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc == cyc && {rise_pulse, fall_pulse, fault, sensor_out} ==
                              {e.rise, e.fall, e.flt, e.so}) begin
            n_pass++;
            $display("event cyc=%0d rise=%b fall=%b fault=%b so=%b ok",
                     cyc, rise_pulse, fall_pulse, fault, sensor_out);
          end else begin
            $display("FAIL event: got cyc=%0d rise=%b fall=%b fault=%b so=%b, expected cyc=%0d rise=%b fall=%b fault=%b so=%b",
                     cyc, rise_pulse, fall_pulse, fault, sensor_out,
                     e.cyc, e.rise, e.fall, e.flt, e.so);
          end
        end
        so_prev  = sensor_out;
        flt_prev = fault;
      end
    end
  end

  initial begin : stimulus
    int t;
    // 1. Reset with the sensor already active, then release.
    tick(2);
    check("reset_outputs", {28'd0, sensor_out, rise_pulse, fall_pulse, fault}, 32'd0);
    rst = 1'b0;
    t = cyc;
    expect_ev(t + 6, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(20);
    raw_sensor = 1'b0;
    expect_ev(cyc + 14, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(30);

    // 2. Glitches of 1, 2, 3 clocks are all rejected.
    for (int w = 1; w <= 3; w++) begin
      raw_sensor = 1'b1;
      tick(w);
      raw_sensor = 1'b0;
      tick(10);
    end
    check("glitch_idle", {31'd0, sensor_out}, 32'd0);

    // 3. Clean presence of 20 clocks.
    t = cyc;
    raw_sensor = 1'b1;
    expect_ev(t + 6, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(20);
    raw_sensor = 1'b0;
    expect_ev(t + 34, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(30);

    // 4. Retrigger from HOLD: drop for 10 clocks, come back, final release.
    t = cyc;
    raw_sensor = 1'b1;
    expect_ev(t + 6, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(20);
    raw_sensor = 1'b0;
    tick(10);
    raw_sensor = 1'b1;
    tick(20);
    raw_sensor = 1'b0;
    expect_ev(t + 64, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(30);

    // 5. Stuck sensor: fault after 64 clocks in ACTIVE, clears after release.
    t = cyc;
    raw_sensor = 1'b1;
    expect_ev(t + 6, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_ev(t + 70, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(99);
    check("nostuck_sensor_out", {31'd0, z_sensor_out}, 32'd1);
    check("nostuck_fault", {31'd0, z_fault}, 32'd0);
    tick(1);
    raw_sensor = 1'b0;
    expect_ev(t + 106, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(30);

    // 6. Reset while in HOLD: output drops at once, no fall pulse.
    t = cyc;
    raw_sensor = 1'b1;
    expect_ev(t + 6, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(20);
    raw_sensor = 1'b0;
    tick(8);
    #2 rst = 1'b1;
    #1;
    check("midhold_rst_sensor_out", {31'd0, sensor_out}, 32'd0);
    check("midhold_rst_fall_pulse", {31'd0, fall_pulse}, 32'd0);
    tick(2);
    rst = 1'b0;
    t = cyc;
    raw_sensor = 1'b1;
    expect_ev(t + 6, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(20);
    raw_sensor = 1'b0;
    expect_ev(t + 34, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(30);

    check("pending_events", exp_q.size(), 32'd0);
    check("nostuck_never_faulted", {31'd0, z_fault_seen}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
